// File: rtl/axis_sm_fifo.sv
// rtl/axis_sm_fifo.sv - AXI-Stream FIFO between FIR output and Wishbone bridge; optional flush via AXIS_SM_FIFO_FLUSH_EN
//
// First-word fall-through FIFO of {tlast, tdata} entries. Write-side
// readiness depends only on registered occupancy, so there is no
// combinational path from m_tready to s_tready. When the FIFO is full, a
// pop in the same cycle does not free a slot for a push. The freed slot
// becomes available on the following cycle.
// Define AXIS_SM_FIFO_FLUSH_EN to add the synchronous flush input.
module axis_sm_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_BITS  = 3
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
`ifdef AXIS_SM_FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  s_tvalid,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [ADDR_BITS:0]    level,
  output logic [15:0]           frame_cnt
);

  localparam logic [ADDR_BITS:0]   LEVEL_FULL = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   LEVEL_ONE  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE    = ADDR_BITS'(1);

  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]    level_q, level_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH:0]   head;
  logic                  flush_w;
  logic                  push;
  logic                  pop;

`ifdef AXIS_SM_FIFO_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Handshake outputs: ready and valid come from registered occupancy only
  assign s_tready = (level_q != LEVEL_FULL) & ~wb_rst_i & ~flush_w;
  assign m_tvalid = (level_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign m_tdata  = head[DATA_WIDTH-1:0];
  assign m_tlast  = head[DATA_WIDTH];

  assign level     = level_q;
  assign frame_cnt = frame_cnt_q;

  // A push is already blocked during flush because s_tready is low then
  assign push = s_tvalid & s_tready;
  assign pop  = m_tvalid & m_tready & ~flush_w;

  // Next-state for pointers, occupancy and frame counter
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    if (flush_w) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (m_tlast) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LEVEL_ONE;
        2'b01:   level_d = level_q - LEVEL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Control state with asynchronous reset that discards all buffered beats
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Storage array: data is never reset, only the pointers qualify it
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
    end
  end

endmodule

// File: tb/tb_axis_sm_fifo.sv
// tb/tb_axis_sm_fifo.sv - directed self-checking bench for axis_sm_fifo
module tb_axis_sm_fifo;

  logic        clk;
  logic        rst;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic [3:0]  level;
  logic [15:0] frame_cnt;
`ifdef AXIS_SM_FIFO_FLUSH_EN
  logic        flush;
`endif

  int checks;
  int errors;

  axis_sm_fifo #(
    .DATA_WIDTH(32),
    .DEPTH(8),
    .ADDR_BITS(3)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
`ifdef AXIS_SM_FIFO_FLUSH_EN
    .flush    (flush),
`endif
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .level    (level),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'(first + i);
      s_tlast  = 1'b0;
      step();
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || level !== 4'd0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset: m_tvalid=%b s_tready=%b level=%0d frame_cnt=%0d required 0 0 0 0",
               m_tvalid, s_tready, level, frame_cnt);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: s_tready=%b required 1", s_tready);
    end
  endtask

  task automatic test_fill();
    m_tready = 1'b0;
    push_beats(32'h11, 8);
    checks++;
    if (level !== 4'd8 || s_tready !== 1'b0 || m_tdata !== 32'h11) begin
      errors++;
      $display("FAIL fill: level=%0d s_tready=%b m_tdata=%h required 8 0 00000011",
               level, s_tready, m_tdata);
    end
    s_tvalid = 1'b1;
    s_tdata  = 32'h19;
    step();
    s_tvalid = 1'b0;
    checks++;
    if (level !== 4'd8 || m_tdata !== 32'h11) begin
      errors++;
      $display("FAIL ninth_beat: level=%0d m_tdata=%h required 8 00000011", level, m_tdata);
    end
  endtask

  task automatic test_drain();
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'(32'h11 + i)) begin
        errors++;
        $display("FAIL drain[%0d]: m_tvalid=%b m_tdata=%h required 1 %h",
                 i, m_tvalid, m_tdata, 32'(32'h11 + i));
      end
      step();
    end
    m_tready = 1'b0;
    checks++;
    if (m_tvalid !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL drain_empty: m_tvalid=%b level=%0d required 0 0", m_tvalid, level);
    end
  endtask

  task automatic test_full_pop();
    m_tready = 1'b0;
    push_beats(32'h20, 8);
    s_tvalid = 1'b1;
    s_tdata  = 32'h28;
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    checks++;
    if (level !== 4'd7 || m_tdata !== 32'h21 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop: level=%0d m_tdata=%h s_tready=%b required 7 00000021 1",
               level, m_tdata, s_tready);
    end
    step();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (m_tdata !== 32'(32'h20 + i)) begin
        errors++;
        $display("FAIL full_pop_order[%0d]: m_tdata=%h required %h", i, m_tdata, 32'(32'h20 + i));
      end
      step();
    end
    m_tready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int nxt;
    nxt = 32'h100;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(nxt);
      nxt++;
    end
    push_beats(32'h100, 3);
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (level !== 4'd3 || m_tdata !== 32'(exp_q[0])) begin
        errors++;
        $display("FAIL back_to_back[%0d]: level=%0d m_tdata=%h required 3 %h",
                 c, level, m_tdata, 32'(exp_q[0]));
      end
      s_tvalid = 1'b1;
      s_tdata  = 32'(nxt);
      m_tready = 1'b1;
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(nxt);
      nxt++;
    end
    s_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'(exp_q[0])) begin
        errors++;
        $display("FAIL back_to_back_tail[%0d]: m_tvalid=%b m_tdata=%h required 1 %h",
                 i, m_tvalid, m_tdata, 32'(exp_q[0]));
      end
      step();
      void'(exp_q.pop_front());
    end
    m_tready = 1'b0;
    checks++;
    if (level !== 4'd0) begin
      errors++;
      $display("FAIL back_to_back_level: level=%0d required 0", level);
    end
  endtask

  task automatic test_tlast();
    logic [31:0] vals [3];
    logic        lasts [3];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    lasts[0] = 1'b0; lasts[1] = 1'b0; lasts[2] = 1'b1;
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL tlast_frame_before: frame_cnt=%0d required 0", frame_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = vals[i];
      s_tlast  = lasts[i];
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_tdata !== vals[i] || m_tlast !== lasts[i]) begin
        errors++;
        $display("FAIL tlast[%0d]: m_tdata=%h m_tlast=%b required %h %b",
                 i, m_tdata, m_tlast, vals[i], lasts[i]);
      end
      step();
    end
    m_tready = 1'b0;
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL tlast_frame_after: frame_cnt=%0d required 1", frame_cnt);
    end
  endtask

  task automatic test_async_reset();
    push_beats(32'h40, 5);
    checks++;
    if (level !== 4'd5) begin
      errors++;
      $display("FAIL async_pre_level: level=%0d required 5", level);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || level !== 4'd0 || frame_cnt !== 16'd0 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: m_tvalid=%b level=%0d frame_cnt=%0d s_tready=%b required 0 0 0 0",
               m_tvalid, level, frame_cnt, s_tready);
    end
    #1;
    rst = 1'b0;
    step();
    s_tvalid = 1'b1;
    s_tdata  = 32'h55;
    step();
    s_tvalid = 1'b0;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h55 || level !== 4'd1) begin
      errors++;
      $display("FAIL async_post_push: m_tvalid=%b m_tdata=%h level=%0d required 1 00000055 1",
               m_tvalid, m_tdata, level);
    end
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
  endtask

`ifdef AXIS_SM_FIFO_FLUSH_EN
  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'(32'h70 + i);
      s_tlast  = 1'b1;
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    step();
    step();
    m_tready = 1'b0;
    push_beats(32'h80, 4);
    checks++;
    if (level !== 4'd4 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL flush_pre: level=%0d frame_cnt=%0d required 4 2", level, frame_cnt);
    end
    flush    = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'h99;
    m_tready = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: s_tready=%b required 0", s_tready);
    end
    step();
    flush    = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    checks++;
    if (level !== 4'd0 || m_tvalid !== 1'b0 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL flush: level=%0d m_tvalid=%b frame_cnt=%0d required 0 0 2",
               level, m_tvalid, frame_cnt);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
`ifdef AXIS_SM_FIFO_FLUSH_EN
    flush    = 1'b0;
`endif
    test_reset();
    test_fill();
    test_drain();
    test_full_pop();
    test_back_to_back();
    test_tlast();
    test_async_reset();
`ifdef AXIS_SM_FIFO_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
